// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : ps2_host_tx
// Description : Host-to-device PS/2 command transmitter. Inhibits the bus,
//               issues a request-to-send, shifts one command byte (LSB
//               first, odd parity, stop) on device-generated clock edges
//               and checks the device acknowledge. Pins are driven
//               open-drain through active-high pull-low enables.
// Ports       : clk           system clock (posedge)
//               clrn          asynchronous active-low reset
//               ps2_clk_in    sensed PS/2 clock pin (asynchronous)
//               ps2_data_in   sensed PS/2 data pin (asynchronous)
//               wrn           active-low write strobe
//               din[7:0]      command byte
//               ps2_clk_low   1 = pull ps2_clk low
//               ps2_data_low  1 = pull ps2_data low
//               busy          transaction in progress
//               done          one-clk end-of-transaction pulse
//               ack_err       device did not acknowledge (sticky)
//               timeout       transaction aborted by timeout (sticky)
// Revision    : 1.0 - initial release
//============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    input  logic       wrn,
    input  logic [7:0] din,
    output logic       ps2_clk_low,
    output logic       ps2_data_low,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [IW-1:0] C_INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INHIBIT  = 3'd1,
        S_REQ      = 3'd2,
        S_SHIFT    = 3'd3,
        S_WAITIDLE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   icnt_q, icnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [3:0]      bitn_q, bitn_d;
    logic [7:0]      byte_q, byte_d;
    logic            par_q, par_d;
    logic            clk_low_q, clk_low_d;
    logic            data_low_q, data_low_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ack_err_q, ack_err_d;
    logic            timeout_q, timeout_d;
    logic [2:0]      clk_sync_q;
    logic [2:0]      dat_sync_q;

    logic w_fall;
    logic w_data_s;
    logic w_lines_idle;

    // Sync chains reset to 1 so releasing reset never looks like a falling edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 3'b111;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[1:0], ps2_data_in};
        end
    end

    assign w_fall       = clk_sync_q[2] & ~clk_sync_q[1];
    assign w_data_s     = dat_sync_q[1];
    // Bus counts as idle only once both lines read high on two consecutive samples.
    assign w_lines_idle = &{clk_sync_q[2:1], dat_sync_q[2:1]};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= S_IDLE;
            icnt_q     <= '0;
            tcnt_q     <= '0;
            bitn_q     <= '0;
            byte_q     <= '0;
            par_q      <= 1'b0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            icnt_q     <= icnt_d;
            tcnt_q     <= tcnt_d;
            bitn_q     <= bitn_d;
            byte_q     <= byte_d;
            par_q      <= par_d;
            clk_low_q  <= clk_low_d;
            data_low_q <= data_low_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        icnt_d     = icnt_q;
        tcnt_d     = tcnt_q;
        bitn_d     = bitn_q;
        byte_d     = byte_q;
        par_d      = par_q;
        clk_low_d  = clk_low_q;
        data_low_d = data_low_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_err_d  = ack_err_q;
        timeout_d  = timeout_q;

        case (state_q)
            S_IDLE: begin
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                // A write in the same cycle as the done pulse is not taken.
                if (!wrn && !done_q) begin
                    byte_d     = din;
                    par_d      = ~^din;
                    ack_err_d  = 1'b0;
                    timeout_d  = 1'b0;
                    busy_d     = 1'b1;
                    icnt_d     = '0;
                    clk_low_d  = 1'b1;
                    data_low_d = 1'b0;
                    state_d    = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (icnt_q == C_INH_LAST) begin
                    data_low_d = 1'b1;
                    state_d    = S_REQ;
                end else begin
                    icnt_d = icnt_q + 1'b1;
                end
            end

            S_REQ: begin
                // Release the clock with data held low: this is the start bit.
                clk_low_d  = 1'b0;
                data_low_d = 1'b1;
                tcnt_d     = '0;
                bitn_d     = '0;
                state_d    = S_SHIFT;
            end

            S_SHIFT: begin
                tcnt_d = tcnt_q + 1'b1;
                if (w_fall) begin
                    bitn_d = bitn_q + 4'd1;
                    if (bitn_q < 4'd8) begin
                        data_low_d = ~byte_q[bitn_q[2:0]];
                    end else if (bitn_q == 4'd8) begin
                        data_low_d = ~par_q;
                    end else if (bitn_q == 4'd9) begin
                        data_low_d = 1'b0;
                    end else begin
                        // Eleventh edge: device pulls data low to acknowledge.
                        ack_err_d  = w_data_s;
                        data_low_d = 1'b0;
                        state_d    = S_WAITIDLE;
                    end
                end
                if ((tcnt_q == C_TMO_LAST) && (state_d == S_SHIFT)) begin
                    clk_low_d  = 1'b0;
                    data_low_d = 1'b0;
                    timeout_d  = 1'b1;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end
            end

            S_WAITIDLE: begin
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                if (w_lines_idle) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    assign ps2_clk_low  = clk_low_q;
    assign ps2_data_low = data_low_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign ack_err      = ack_err_q;
    assign timeout      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : tb_ps2_host_tx
// Description : Self-checking bench for ps2_host_tx. A behavioural PS/2
//               device clocks the frame and records the line; a scoreboard
//               compares each transaction outcome against a frame model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_ps2_host_tx;

    localparam int INH = 8;
    localparam int TMO = 400;

    logic       clk   = 1'b0;
    logic       clrn  = 1'b0;
    logic       wrn   = 1'b1;
    logic [7:0] din   = 8'h00;
    logic       ps2_clk_low, ps2_data_low, busy, done, ack_err, timeout;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_pin, ps2_data_pin;

    // Open-drain wired-AND of host and device drivers.
    assign ps2_clk_pin  = dev_clk  & ~ps2_clk_low;
    assign ps2_data_pin = dev_data & ~ps2_data_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .ps2_clk_in  (ps2_clk_pin),
        .ps2_data_in (ps2_data_pin),
        .wrn         (wrn),
        .din         (din),
        .ps2_clk_low (ps2_clk_low),
        .ps2_data_low(ps2_data_low),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout     (timeout)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        logic       exp_ack_err;
        logic       exp_timeout;
        logic       chk_frame;
    } exp_t;

    exp_t sb[$];
    logic cap[$];
    int   checks   = 0;
    int   fails    = 0;
    int   done_cnt = 0;
    bit   dev_en   = 1'b0;
    bit   dev_ack  = 1'b1;
    bit   dev_active = 1'b0;
    int   dev_max  = 11;
    logic prev_done = 1'b0;

    // Line levels a device sees: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            if (b[i]) ones++;
        end
        f[9]  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every done pulse pops one expected outcome.
    always @(negedge clk) begin
        exp_t        e;
        logic [10:0] act;
        if (clrn && done) begin
            done_cnt++;
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_err", {31'd0, ack_err}, {31'd0, e.exp_ack_err});
                check("timeout", {31'd0, timeout}, {31'd0, e.exp_timeout});
                check("busy_at_done", {31'd0, busy}, 32'd0);
                if (e.chk_frame) begin
                    act = '1;
                    for (int i = 0; i < cap.size() && i < 11; i++) act[i] = cap[i];
                    check("frame_len", cap.size(), 32'd11);
                    check("frame", {21'd0, act}, {21'd0, model_frame(e.b)});
                end
            end
        end
        prev_done = done;
    end

    // Device: clocks 11 falling edges (40 ns low / 40 ns high), samples the
    // line late in each high phase, and pulls data low for the ack.
    task automatic run_frame();
        bit stop_now;
        stop_now   = 1'b0;
        dev_active = 1'b1;
        cap.delete();
        repeat (2) @(negedge clk);
        cap.push_back(ps2_data_pin);
        for (int e = 1; e <= 11 && !stop_now; e++) begin
            @(negedge clk);
            dev_clk = 1'b0;
            repeat (2) @(negedge clk);
            dev_clk = 1'b1;
            if (e == dev_max) begin
                stop_now = 1'b1;
            end else begin
                @(negedge clk);
                if (e <= 10) cap.push_back(ps2_data_pin);
                if (e == 10 && dev_ack) dev_data = 1'b0;
                if (e == 11) dev_data = 1'b1;
            end
        end
        dev_data   = 1'b1;
        dev_en     = 1'b0;
        dev_active = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (dev_en && clrn && ps2_clk_pin && !ps2_data_pin) run_frame();
        end
    end

    task automatic push_exp(input logic [7:0] b, input logic ae, input logic to, input logic fr);
        exp_t e;
        e.b = b; e.exp_ack_err = ae; e.exp_timeout = to; e.chk_frame = fr;
        sb.push_back(e);
    endtask

    // Returns at the first negedge after the write was sampled.
    task automatic do_write(input logic [7:0] b);
        @(negedge clk);
        wrn = 1'b0;
        din = b;
        @(negedge clk);
        wrn = 1'b1;
        din = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("busy_release", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
    endtask

    task automatic run_txn(input logic [7:0] b, input bit with_dev, input bit ack);
        if (with_dev) push_exp(b, ~ack, 1'b0, 1'b1);
        else          push_exp(b, 1'b0, 1'b1, 1'b0);
        dev_ack = ack;
        dev_max = 11;
        dev_en  = with_dev;
        do_write(b);
        wait_idle();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        int saved_done;
        int m;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        check("rst_clk_low",  {31'd0, ps2_clk_low},  32'd0);
        check("rst_data_low", {31'd0, ps2_data_low}, 32'd0);
        check("rst_busy",     {31'd0, busy},         32'd0);
        check("rst_done",     {31'd0, done},         32'd0);
        check("rst_ack_err",  {31'd0, ack_err},      32'd0);
        check("rst_timeout",  {31'd0, timeout},      32'd0);
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        // 0xED with inhibit/RTS timing and an ignored write while busy.
        push_exp(8'hED, 1'b0, 1'b0, 1'b1);
        dev_ack = 1'b1; dev_max = 11; dev_en = 1'b1;
        do_write(8'hED);
        ok = 1'b1;
        for (int i = 0; i < INH; i++) begin
            if (i > 0) @(negedge clk);
            if (!(ps2_clk_low === 1'b1 && ps2_data_low === 1'b0 && busy === 1'b1)) ok = 1'b0;
        end
        check("inhibit_phase", {31'd0, ok}, 32'd1);
        @(negedge clk);
        check("rts_phase", {30'd0, ps2_clk_low, ps2_data_low}, 32'd3);
        @(negedge clk);
        check("shift_entry", {29'd0, ps2_clk_low, ps2_data_low, busy}, 32'd3);
        repeat (12) @(negedge clk);
        check("busy_mid_frame", {31'd0, busy}, 32'd1);
        wrn = 1'b0; din = 8'h00;
        @(negedge clk);
        wrn = 1'b1;
        saved_done = done_cnt;
        wait_idle();
        check("one_done_0xED", done_cnt - saved_done, 32'd1);

        // Nack on 0x01.
        run_txn(8'h01, 1'b1, 1'b0);

        // Timeout on 0xFF: device never clocks.
        push_exp(8'hFF, 1'b0, 1'b1, 1'b0);
        dev_en = 1'b0;
        do_write(8'hFF);
        n = 0;
        while (!(ps2_data_low === 1'b1 && ps2_clk_low === 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_shift", {31'd0, (n < 100)}, 32'd1);
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", n, TMO);
        check("timeout_pins", {30'd0, ps2_clk_low, ps2_data_low}, 32'd0);
        wait_idle();

        // Next write clears the sticky timeout.
        push_exp(8'h3C, 1'b0, 1'b0, 1'b1);
        dev_ack = 1'b1; dev_max = 11; dev_en = 1'b1;
        do_write(8'h3C);
        check("timeout_cleared", {31'd0, timeout}, 32'd0);
        wait_idle();

        // Reset after the fourth falling edge.
        dev_ack = 1'b1; dev_max = 4; dev_en = 1'b1;
        do_write(8'hA5);
        n = 0;
        while (!dev_active && n < 200) begin @(negedge clk); n++; end
        while (dev_active && n < 400)  begin @(negedge clk); n++; end
        check("reset_setup", {31'd0, (n < 400)}, 32'd1);
        saved_done = done_cnt;
        #3;
        clrn = 1'b0;
        #1;
        check("rst_async_pins", {30'd0, ps2_clk_low, ps2_data_low}, 32'd0);
        check("rst_async_busy", {30'd0, busy, done}, 32'd0);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        dev_en = 1'b0;
        repeat (5) @(negedge clk);
        check("no_done_on_reset", done_cnt - saved_done, 32'd0);

        run_txn(8'hF4, 1'b1, 1'b1);

        // Randomized transactions.
        for (int t = 0; t < 16; t++) begin
            b = 8'($urandom);
            m = int'($urandom_range(0, 7));
            if (m == 0) run_txn(b, 1'b0, 1'b1);
            else        run_txn(b, 1'b1, (m > 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
